// File: rtl/sram_model_if.sv
// Bus between a requester and the behavioural SRAM model.
// The requester holds i_enable with a stable request until o_ready,
// then drops i_enable for at least one cycle before the next transfer.
interface sram_model_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      i_enable;
    logic                      i_rw;
    logic [ADDR_WIDTH-1:0]     i_address;
    logic [DATA_WIDTH-1:0]     i_wdata;
    logic [DATA_WIDTH/8-1:0]   i_wmask;
    logic [DATA_WIDTH-1:0]     o_rdata;
    logic                      o_ready;
    logic                      o_error;

    modport master (
        output i_enable, i_rw, i_address, i_wdata, i_wmask,
        input  o_rdata, o_ready, o_error
    );

    modport slave (
        input  i_enable, i_rw, i_address, i_wdata, i_wmask,
        output o_rdata, o_ready, o_error
    );
endinterface

// File: rtl/sram_model.sv
// Behavioural SRAM with independent read/write wait states, byte-lane
// write strobes and out-of-range detection. Stand-in for external memory
// behind the CPU bus.
//
// Optional feature macro: SRAM_MODEL_JITTER_EN
//   When defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11) adds
//   0..2^JITTER_BITS-1 extra wait cycles to each access.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | no transfer; a high i_enable is captured as a new request
// S_WAIT | counting down the access latency
// S_DONE | access completed; o_ready held until i_enable drops
module sram_model #(
    parameter int          DATA_WIDTH    = 32,
    parameter int          DEPTH         = 32'h0040_0000,
    parameter int          ADDR_WIDTH    = 32,
    parameter int          READ_LATENCY  = 4,
    parameter int          WRITE_LATENCY = 4,
    parameter int          JITTER_BITS   = 2,
    parameter logic [15:0] JITTER_SEED   = 16'hACE1,
    parameter string       INIT_FILE     = ""
) (
    input logic         i_clock,
    input logic         i_reset_n,
    sram_model_if.slave bus
);

    localparam int BYTES    = DATA_WIDTH / 8;
    localparam int SHIFT    = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int MEM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BASE_MAX = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    // Counter is sized for the worst case including jitter, even when
    // jitter is compiled out, so the width never depends on the macro.
    localparam int MAX_LAT  = BASE_MAX + (1 << JITTER_BITS) - 1;
    localparam int CNT_W    = $clog2(MAX_LAT + 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        jitter;
    logic [CNT_W-1:0]        lat_load;
    logic [ADDR_WIDTH-1:0]   req_idx;
    logic                    req_in_range;
    logic                    complete;

    logic                    cap_rw;
    logic                    cap_in_range;
    logic [MEM_AW-1:0]       cap_idx;
    logic [DATA_WIDTH-1:0]   cap_wdata;
    logic [BYTES-1:0]        cap_wmask;

    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    ready_q;
    logic                    error_q;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

`ifdef SRAM_MODEL_JITTER_EN
    logic [15:0] lfsr;

    // Free-running LFSR; its low bits at capture time give the extra wait.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            lfsr <= JITTER_SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign jitter = CNT_W'(lfsr[JITTER_BITS-1:0]);
`else
    assign jitter = '0;
`endif

    assign req_idx      = bus.i_address >> SHIFT;
    assign req_in_range = ({1'b0, req_idx} < DEPTH_W);
    assign lat_load     = (bus.i_rw ? CNT_W'(WRITE_LATENCY) : CNT_W'(READ_LATENCY))
                          + jitter - CNT_W'(1);
    assign complete     = (state == S_WAIT) && bus.i_enable && (cnt == '0);

    // State register.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; dropping i_enable in S_WAIT aborts the access.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (bus.i_enable) state_nxt = S_WAIT;
            S_WAIT: begin
                if (!bus.i_enable) begin
                    state_nxt = S_IDLE;
                end else if (cnt == '0) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: if (!bus.i_enable) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request capture, wait counter and registered response outputs.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt          <= '0;
            cap_rw       <= 1'b0;
            cap_in_range <= 1'b0;
            cap_idx      <= '0;
            cap_wdata    <= '0;
            cap_wmask    <= '0;
            rdata_q      <= '0;
            ready_q      <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            if (state == S_IDLE && bus.i_enable) begin
                cap_rw       <= bus.i_rw;
                cap_in_range <= req_in_range;
                cap_idx      <= req_idx[MEM_AW-1:0];
                cap_wdata    <= bus.i_wdata;
                cap_wmask    <= bus.i_wmask;
                cnt          <= lat_load;
            end else if (state == S_WAIT && bus.i_enable && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end

            if (complete) begin
                ready_q <= 1'b1;
                if (!cap_in_range) begin
                    rdata_q <= '0;
                    error_q <= 1'b1;
                end else if (!cap_rw) begin
                    rdata_q <= mem[cap_idx];
                end
            end else if (state == S_DONE && !bus.i_enable) begin
                ready_q <= 1'b0;
                error_q <= 1'b0;
            end
        end
    end

    // Byte-lane write on completion; memory is deliberately not reset.
    always_ff @(posedge i_clock) begin
        if (complete && cap_rw && cap_in_range) begin
            for (int b = 0; b < BYTES; b++) begin
                if (cap_wmask[b]) begin
                    mem[cap_idx][8*b +: 8] <= cap_wdata[8*b +: 8];
                end
            end
        end
    end

    assign bus.o_rdata = rdata_q;
    assign bus.o_ready = ready_q;
    assign bus.o_error = error_q;

endmodule
